// File: rtl/dmem_responder.sv
// dmem_responder: data-memory load/store responder with programmable wait states (optional DMEM_ALIGN_CHECK_EN misalign fault); ports clk, rst, MemRead, MemWrite, A, WD -> ReadData, Busy, Ready, Fault
module dmem_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] ReadData,
  output logic             Busy,
  output logic             Ready,
  output logic             Fault
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic [AW-1:0] idx_q;
  logic [WIDTH-1:0] wd_q;
  logic wr_q, rd_q, mis_q, req, mis;
  logic [WIDTH-1:0] mem [DEPTH];
  logic unused_a;
  assign req = MemRead | MemWrite;
  assign unused_a = ^{A[WIDTH-1:AW+2], A[1:0]};
`ifdef DMEM_ALIGN_CHECK_EN
  assign mis = |A[1:0];
`else
  assign mis = 1'b0;
`endif
  always_comb begin
    state_n = state == IDLE ? (req ? BUSY : IDLE) :
              state == BUSY ? (cnt == 4'd0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      ReadData <= '0;
      Busy <= 1'b0;
      Ready <= 1'b0;
      Fault <= 1'b0;
      idx_q <= '0;
      wd_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      mis_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      Busy <= state_n == BUSY;
      Ready <= state_n == DONE;
      Fault <= state_n == DONE && mis_q;
      if (state == IDLE && req) begin
        cnt <= 4'(WAIT_CYCLES);
        idx_q <= A[AW+1:2];
        wd_q <= WD;
        wr_q <= MemWrite;
        rd_q <= MemRead;
        mis_q <= mis;
      end
      if (state == BUSY) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        else begin
          if (wr_q && !mis_q) mem[idx_q] <= wd_q;
          // a write-only completion leaves ReadData alone; read+write or misaligned returns 0
          if (rd_q || mis_q) ReadData <= (wr_q || mis_q) ? '0 : mem[idx_q];
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized self-checking bench for dmem_responder against a word-array model
module tb_dmem_responder;
  localparam int WC = 2;
  localparam int DEPTH = 64;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] A = '0, WD = '0, ReadData;
  logic Busy, Ready, Fault;
  int checks = 0, failures = 0;
  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_rd;
  logic exp_flt;
  dmem_responder #(.WIDTH(32), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .A(A), .WD(WD),
    .ReadData(ReadData), .Busy(Busy), .Ready(Ready), .Fault(Fault)
  );
  always #5 clk = ~clk;
  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    exp_rd = '0;
    exp_flt = 1'b0;
  endfunction
  function automatic void model_op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
    int i;
    i = int'((a >> 2) % DEPTH);
    if (ALIGN && a[1:0] != 2'b00) begin
      exp_rd = '0;
      exp_flt = 1'b1;
    end else begin
      exp_flt = 1'b0;
      if (wr) mdl[i] = wd;
      if (wr && rd) exp_rd = '0;
      else if (rd) exp_rd = mdl[i];
    end
  endfunction
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd, input bit scr,
                      output logic [31:0] rdata, output int lat, output int busy_n, output logic flt, output logic early_flt);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; A = a; WD = wd;
    @(posedge clk);
    @(negedge clk);
    busy_n = int'(Busy);
    early_flt = Fault;
    lat = 0;
    while (!Ready && lat < 40) begin
      if (scr) begin A = $urandom; WD = $urandom; end
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (Busy) busy_n++;
      if (!Ready && Fault) early_flt = 1'b1;
    end
    rdata = ReadData;
    flt = Fault;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks += 4;
    if (ReadData !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", ReadData); end
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    if (Ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", Ready); end
    if (Fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", Fault); end
    rst = 1'b0;
    model_clear();
  endtask
  task automatic test_read_after_reset;
    logic [31:0] rd; int lat, bn; logic f, ef;
    xact(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h10, 32'h0);
    checks += 4;
    if (lat !== WC + 1) begin failures++; $display("FAIL rar_latency got=%0d exp=%0d", lat, WC + 1); end
    if (bn !== WC + 1) begin failures++; $display("FAIL rar_busy_cycles got=%0d exp=%0d", bn, WC + 1); end
    if (rd !== exp_rd) begin failures++; $display("FAIL rar_data got=%h exp=%h", rd, exp_rd); end
    @(negedge clk);
    if (Ready !== 1'b0) begin failures++; $display("FAIL rar_ready_pulse got=%b exp=0", Ready); end
  endtask
  task automatic test_write_read;
    logic [31:0] rd; int lat, bn; logic f, ef;
    xact(1'b0, 1'b1, 32'h08, 32'hDEADBEEF, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b0, 1'b1, 32'h08, 32'hDEADBEEF);
    checks += 2;
    if (lat !== WC + 1) begin failures++; $display("FAIL wr_latency got=%0d exp=%0d", lat, WC + 1); end
    xact(1'b1, 1'b0, 32'h08, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h08, 32'h0);
    if (rd !== exp_rd) begin failures++; $display("FAIL wr_rd_data got=%h exp=%h", rd, exp_rd); end
  endtask
  task automatic test_alias;
    logic [31:0] rd; int lat, bn; logic f, ef;
    xact(1'b0, 1'b1, 32'h100, 32'h12345678, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b0, 1'b1, 32'h100, 32'h12345678);
    xact(1'b1, 1'b0, 32'h000, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h000, 32'h0);
    checks++;
    if (rd !== exp_rd) begin failures++; $display("FAIL alias_data got=%h exp=%h", rd, exp_rd); end
  endtask
  task automatic test_ignore;
    logic [31:0] rd; int lat, bn; logic f, ef;
    xact(1'b0, 1'b1, 32'h04, 32'hA5A5A5A5, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b0, 1'b1, 32'h04, 32'hA5A5A5A5);
    xact(1'b1, 1'b0, 32'h04, 32'h0, 1'b1, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h04, 32'h0);
    checks += 3;
    if (rd !== exp_rd) begin failures++; $display("FAIL ignore_data got=%h exp=%h", rd, exp_rd); end
    xact(1'b1, 1'b0, 32'h0C, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h0C, 32'h0);
    if (rd !== exp_rd) begin failures++; $display("FAIL ignore_0c got=%h exp=%h", rd, exp_rd); end
    xact(1'b1, 1'b0, 32'h04, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h04, 32'h0);
    if (rd !== exp_rd) begin failures++; $display("FAIL ignore_04 got=%h exp=%h", rd, exp_rd); end
  endtask
  task automatic test_reset_mid;
    logic [31:0] rd; int lat, bn; logic f, ef, saw;
    @(negedge clk);
    MemWrite = 1'b1; MemRead = 1'b0; A = 32'h20; WD = 32'hFFFFFFFF;
    @(negedge clk);
    saw = Ready;
    @(negedge clk);
    saw |= Ready;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; MemWrite = 1'b0;
    repeat (6) begin @(negedge clk); saw |= Ready; end
    model_clear();
    checks += 2;
    if (saw !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%b exp=0", saw); end
    xact(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h20, 32'h0);
    if (rd !== exp_rd) begin failures++; $display("FAIL rstmid_data got=%h exp=%h", rd, exp_rd); end
  endtask
  task automatic test_misaligned;
    logic [31:0] rd; int lat, bn; logic f, ef;
    xact(1'b0, 1'b1, 32'h22, 32'h1, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b0, 1'b1, 32'h22, 32'h1);
    checks += 4;
    if (f !== exp_flt) begin failures++; $display("FAIL mis_fault got=%b exp=%b", f, exp_flt); end
    if (ef !== 1'b0) begin failures++; $display("FAIL mis_fault_early got=%b exp=0", ef); end
    @(negedge clk);
    if (Fault !== 1'b0) begin failures++; $display("FAIL mis_fault_clear got=%b exp=0", Fault); end
    xact(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, 32'h20, 32'h0);
    if (rd !== exp_rd) begin failures++; $display("FAIL mis_data got=%h exp=%h", rd, exp_rd); end
  endtask
  task automatic test_both;
    logic [31:0] rd, a, d; int lat, bn; logic f, ef;
    a = {$urandom_range(0, 255), 2'b00};
    d = $urandom;
    xact(1'b1, 1'b0, a, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, a, 32'h0);
    xact(1'b1, 1'b1, a, d, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b1, a, d);
    checks += 2;
    if (rd !== exp_rd) begin failures++; $display("FAIL both_data got=%h exp=%h", rd, exp_rd); end
    xact(1'b1, 1'b0, a, 32'h0, 1'b0, rd, lat, bn, f, ef);
    model_op(1'b1, 1'b0, a, 32'h0);
    if (rd !== exp_rd) begin failures++; $display("FAIL both_readback got=%h exp=%h", rd, exp_rd); end
  endtask
  task automatic test_random;
    logic [31:0] rd, a, d; int lat, bn, k; logic f, ef, r, w;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 3);
      r = k != 1; w = k != 0 && k != 3;
      a = $urandom;
      if (n % 2 == 0) a[1:0] = 2'b00;
      a[31:10] = (n % 3 == 0) ? a[31:10] : '0;
      d = $urandom;
      xact(r, w, a, d, n % 4 == 1, rd, lat, bn, f, ef);
      model_op(r, w, a, d);
      checks += 4;
      if (rd !== exp_rd) begin failures++; $display("FAIL rand_data n=%0d got=%h exp=%h", n, rd, exp_rd); end
      if (lat !== WC + 1) begin failures++; $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, WC + 1); end
      if (bn !== WC + 1) begin failures++; $display("FAIL rand_busy n=%0d got=%0d exp=%0d", n, bn, WC + 1); end
      if (f !== exp_flt) begin failures++; $display("FAIL rand_fault n=%0d got=%b exp=%b", n, f, exp_flt); end
    end
  endtask
  task automatic test_back_to_back;
    int first, second, cyc;
    first = -1; second = -1;
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; A = 32'h08;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (Ready && first < 0) first = cyc;
      else if (Ready && second < 0) second = cyc;
    end
    MemRead = 1'b0;
    repeat (WC + 3) @(negedge clk);
    checks++;
    if (second - first !== WC + 3) begin failures++; $display("FAIL b2b_spacing got=%0d exp=%0d", second - first, WC + 3); end
  endtask
  initial begin
    test_reset();
    test_read_after_reset();
    test_write_read();
    test_alias();
    test_ignore();
    test_reset_mid();
    test_misaligned();
    test_both();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
